// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline register with 2-entry skid buffer, flush and occupancy
// Optional PIPE_SKID_STAGE_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_skid_stage #(
  parameter int                CTRL_W      = 8,
  parameter int                DATA_W      = 96,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stale enable/rw bits must never leak downstream while the slot is empty.
  assign out_ctrl = out_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_data = main_data;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      level     <= 2'd0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      level     <= 2'd0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= S_ONE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
            level     <= 2'd1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= S_TWO;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            level     <= 2'd2;
          end else if (out_fire) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            level     <= 2'd0;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= S_ONE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
            level     <= 2'd1;
          end
        end
        default: begin
          state     <= S_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          level     <= 2'd0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (!out_valid && !flush && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - bench for pipe_skid_stage against a capacity-2 FIFO queue model
module tb_pipe_skid_stage;

  localparam int CW = 8;
  localparam int DW = 96;
  localparam int NW = 16;
  localparam logic [CW-1:0] BUB = 8'hA5;

  logic          CLK;
  logic          CLR;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    level;
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;
`endif

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB), .CNT_W(NW)) dut (
    .CLK(CLK), .CLR(CLR), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .level(level)
`ifdef PIPE_SKID_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] m_stall = '0;
  logic [NW-1:0] m_bub = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("level", 128'(level), 128'(q.size()));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("out_ctrl", 128'(out_ctrl), 128'((q.size() > 0) ? q[0].c : BUB));
    if (q.size() > 0) chk("out_data", 128'(out_data), 128'(q[0].d));
`ifdef PIPE_SKID_STAGE_PERF_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bub));
`endif
  endtask

  // Called at a falling edge: drive, predict, advance one clock, compare.
  task automatic step(input logic clr, input logic fl, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    bit inf;
    bit outf;
    CLR = clr; flush = fl; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    inf  = iv && (q.size() < 2);
    outf = (q.size() > 0) && ordy;
    if (clr) begin
      m_stall = '0;
      m_bub   = '0;
    end else begin
      if (q.size() > 0 && !ordy && m_stall != '1) m_stall = m_stall + 1'b1;
      if (q.size() == 0 && !fl && m_bub != '1) m_bub = m_bub + 1'b1;
    end
    @(posedge CLK);
    if (clr || fl) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{c, d});
    end
    @(negedge CLK);
    compare();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    CLR = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(negedge CLK);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_out_ctrl_lit", 128'(out_ctrl), 128'(8'hA5));
    chk("rst_level_lit", 128'(level), 128'(0));

    // Streaming: one per cycle, level pinned at 1.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, CW'(i), DW'(i * 3), 1'b1);
      chk("stream_ctrl_lit", 128'(out_ctrl), 128'(i));
      chk("stream_data_lit", 128'(out_data), 128'(i * 3));
      chk("stream_level_lit", 128'(level), 128'(1));
    end
    idle(1'b1);

    // Back-pressure fills both slots, then drains in order.
    step(1'b0, 1'b0, 1'b1, 8'd1, 96'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd2, 96'd2, 1'b0);
    chk("bp_in_ready_lit", 128'(in_ready), 128'(0));
    step(1'b0, 1'b0, 1'b1, 8'd3, 96'd3, 1'b0);
    chk("bp_level_lit", 128'(level), 128'(2));
    chk("bp_head_lit", 128'(out_ctrl), 128'(1));
    step(1'b0, 1'b0, 1'b1, 8'd3, 96'd3, 1'b1);
    chk("bp_drain2_lit", 128'(out_ctrl), 128'(2));
    step(1'b0, 1'b0, 1'b1, 8'd3, 96'd3, 1'b1);
    chk("bp_drain3_lit", 128'(out_ctrl), 128'(3));
    idle(1'b1);

    // Flush at level 2 drops everything, including the entry offered that cycle.
    step(1'b0, 1'b0, 1'b1, 8'd1, 96'd1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd2, 96'd2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'd7, 96'd7, 1'b0);
    chk("flush_level_lit", 128'(level), 128'(0));
    chk("flush_ctrl_lit", 128'(out_ctrl), 128'(8'hA5));
    idle(1'b1);
    chk("flush_no7_lit", 128'(out_valid), 128'(0));

    // Simultaneous in/out in ONE, then CLR at level 2.
    step(1'b0, 1'b0, 1'b1, 8'd5, 96'd5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd6, 96'd6, 1'b1);
    chk("sim_ctrl_lit", 128'(out_ctrl), 128'(6));
    chk("sim_level_lit", 128'(level), 128'(1));
    step(1'b0, 1'b0, 1'b1, 8'd8, 96'd8, 1'b0);
    chk("pre_clr_level_lit", 128'(level), 128'(2));
    step(1'b1, 1'b0, 1'b1, 8'd9, 96'd9, 1'b1);
    chk("clr_level_lit", 128'(level), 128'(0));

    // Randomized traffic with occasional flush and CLR.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 9) < 7, CW'($urandom),
           {$urandom, $urandom, $urandom}, $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
